// File: rtl/sprite_line_eval_pkg.sv
// Shared constants for the scanline sprite evaluator: sizes, OAM field layout,
// hidden-entry value and FSM state encodings.
package sprite_line_eval_pkg;

    localparam int unsigned SPRITE_NUM_MAX_DEF  = 64;
    localparam int unsigned LINE_SPRITE_MAX_DEF = 8;
    localparam int unsigned TILE_H_DEF          = 8;
    localparam int unsigned BYTE                = 8;

    // OAM / view RAM word: posX [31:24], posY [23:16], tileIndex [15:8], attr [7:0]
    typedef struct packed {
        logic [BYTE-1:0] posX;
        logic [BYTE-1:0] posY;
        logic [BYTE-1:0] tileIndex;
        logic [BYTE-1:0] attr;
    } oam_entry_t;

    localparam logic [31:0] HIDDEN_ENTRY = 32'hFFFF_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sprite_hit_cmp.sv
// Combinational 1-D sprite coverage test, done in 9 bits so positions near 255 do not wrap.
// Usable for the Y (line) check or an X (pixel) check.
module sprite_hit_cmp
    import sprite_line_eval_pkg::*;
#(
    parameter int unsigned SIZE = TILE_H_DEF
) (
    input  logic [BYTE-1:0] i_pos,
    input  logic [BYTE-1:0] i_coord,
    output logic            o_hit
);

    logic [BYTE:0] w_lo;
    logic [BYTE:0] w_hi;
    logic [BYTE:0] w_coord;

    assign w_lo    = {1'b0, i_pos};
    assign w_hi    = w_lo + (BYTE+1)'(SIZE);
    assign w_coord = {1'b0, i_coord};

    // Position 8'hFF marks a hidden sprite and never matches.
    assign o_hit = (i_pos != 8'hFF) && (w_coord >= w_lo) && (w_coord < w_hi);

endmodule

// File: rtl/sprite_line_eval.sv
// Scans OAM during hblank, writes hits for the next line into the inactive view RAM bank,
// pads the rest with hidden entries, then flips the bank. Optional: SPRITE_OVERFLOW_EN.
module sprite_line_eval
    import sprite_line_eval_pkg::*;
#(
    parameter int unsigned SPRITE_NUM_MAX  = SPRITE_NUM_MAX_DEF,
    parameter int unsigned LINE_SPRITE_MAX = LINE_SPRITE_MAX_DEF,
    parameter int unsigned TILE_H          = TILE_H_DEF
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               lineStart,
    input  logic [7:0]                         nextLineY,
    output logic [$clog2(SPRITE_NUM_MAX)-1:0]  oamAddr,
    input  logic [31:0]                        oamData,
    output logic                               viewWe,
    output logic [$clog2(LINE_SPRITE_MAX):0]   viewAddr,
    output logic [31:0]                        viewData,
    output logic                               viewBank,
    output logic [$clog2(LINE_SPRITE_MAX):0]   lineCount,
`ifdef SPRITE_OVERFLOW_EN
    output logic                               overflow,
`endif
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned IW = $clog2(SPRITE_NUM_MAX);
    localparam int unsigned LW = $clog2(LINE_SPRITE_MAX);

    localparam logic [IW-1:0] IDX_LAST  = IW'(SPRITE_NUM_MAX - 1);
    localparam logic [LW:0]   CNT_FULL  = (LW+1)'(LINE_SPRITE_MAX);
    localparam logic [LW-1:0] FILL_LAST = LW'(LINE_SPRITE_MAX - 1);

    logic [2:0]      r_state,      w_state;
    logic [7:0]      r_y,          w_y;
    logic [IW-1:0]   r_idx,        w_idx;
    logic [LW:0]     r_count,      w_count;
    logic [LW-1:0]   r_fill,       w_fill;
    logic            r_bank,       w_bank;
    logic [LW:0]     r_line_count, w_line_count;
    logic            r_done,       w_done;
    logic            r_we,         w_we;
    logic [LW:0]     r_waddr,      w_waddr;
    logic [31:0]     r_wdata,      w_wdata;
`ifdef SPRITE_OVERFLOW_EN
    logic            r_pend,       w_pend;
    logic            r_overflow,   w_overflow;
`endif

    oam_entry_t w_entry;
    logic       w_hit;

    assign w_entry = oam_entry_t'(oamData);

    sprite_hit_cmp #(
        .SIZE    (TILE_H)
    ) u_hit_y (
        .i_pos   (w_entry.posY),
        .i_coord (r_y),
        .o_hit   (w_hit)
    );

    always_comb begin
        w_state      = r_state;
        w_y          = r_y;
        w_idx        = r_idx;
        w_count      = r_count;
        w_fill       = r_fill;
        w_bank       = r_bank;
        w_line_count = r_line_count;
        w_done       = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_waddr;
        w_wdata      = r_wdata;
`ifdef SPRITE_OVERFLOW_EN
        w_pend       = r_pend;
        w_overflow   = r_overflow;
`endif
        // A new lineStart always (re)launches the pass, aborting any pass in flight.
        if (lineStart) begin
            w_state = ST_FETCH;
            w_y     = nextLineY;
            w_idx   = '0;
            w_count = '0;
`ifdef SPRITE_OVERFLOW_EN
            w_pend  = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: w_state = ST_EVAL;
                ST_EVAL: begin
                    w_state = ST_FETCH;
                    w_idx   = r_idx + 1'b1;
                    if (w_hit) begin
                        if (r_count != CNT_FULL) begin
                            w_we    = 1'b1;
                            w_waddr = {~r_bank, r_count[LW-1:0]};
                            w_wdata = w_entry;
                            w_count = r_count + 1'b1;
                        end else begin
`ifdef SPRITE_OVERFLOW_EN
                            w_pend  = 1'b1;
`endif
                        end
                    end
`ifdef SPRITE_OVERFLOW_EN
                    if (r_idx == IDX_LAST) begin
`else
                    if ((r_idx == IDX_LAST) || (w_count == CNT_FULL)) begin
`endif
                        w_state = (w_count == CNT_FULL) ? ST_DONE : ST_FILL;
                        w_fill  = w_count[LW-1:0];
                    end
                end
                ST_FILL: begin
                    w_we    = 1'b1;
                    w_waddr = {~r_bank, r_fill};
                    w_wdata = HIDDEN_ENTRY;
                    w_fill  = r_fill + 1'b1;
                    if (r_fill == FILL_LAST) begin
                        w_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state      = ST_IDLE;
                    w_bank       = ~r_bank;
                    w_line_count = r_count;
                    w_done       = 1'b1;
`ifdef SPRITE_OVERFLOW_EN
                    w_overflow   = r_pend;
`endif
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_y          <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_fill       <= '0;
            r_bank       <= 1'b0;
            r_line_count <= '0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
`ifdef SPRITE_OVERFLOW_EN
            r_pend       <= 1'b0;
            r_overflow   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_y          <= w_y;
            r_idx        <= w_idx;
            r_count      <= w_count;
            r_fill       <= w_fill;
            r_bank       <= w_bank;
            r_line_count <= w_line_count;
            r_done       <= w_done;
            r_we         <= w_we;
            r_waddr      <= w_waddr;
            r_wdata      <= w_wdata;
`ifdef SPRITE_OVERFLOW_EN
            r_pend       <= w_pend;
            r_overflow   <= w_overflow;
`endif
        end
    end

    assign oamAddr   = r_idx;
    assign viewWe    = r_we;
    assign viewAddr  = r_waddr;
    assign viewData  = r_wdata;
    assign viewBank  = r_bank;
    assign lineCount = r_line_count;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
`ifdef SPRITE_OVERFLOW_EN
    assign overflow  = r_overflow;
`endif

endmodule
